// File: rtl/fifo36_pkg.sv
// Shared constants and types for the FIFO36 synchronous model.
// Ports: none (package only).
package fifo36_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PAR_W  = 8;
  localparam int unsigned WORD_W = DATA_W + PAR_W;

  localparam int unsigned DEF_DEPTH               = 512;
  localparam int unsigned DEF_ALMOST_FULL_OFFSET  = 500;
  localparam int unsigned DEF_ALMOST_EMPTY_OFFSET = 100;

  // Stored word layout: {data, parity/side bits}
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/fifo36_ram.sv
// Simple dual-port storage array for the FIFO36 model.
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - word to store
//   rd_addr - read address, sampled every rising edge
//   rd_data - registered read data (old contents on same-address write)
module fifo36_ram
  import fifo36_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output word_t         rd_data
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo36_sync_model.sv
// Single-clock first-word-fall-through FIFO with the FIFO36 primitive port set.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   io_din/io_dip         - write word {data, side bits}; io_wren writes
//   io_rden               - pops the head word
//   io_dout/io_dop        - head word (zero while io_empty)
//   io_full/io_empty      - occupancy flags
//   io_almostFull/Empty   - registered threshold flags
//   io_wrCount/io_rdCount - write/read pointers
//   io_count              - occupancy 0..DEPTH
//   io_wrErr/io_rdErr     - one-cycle pulses for rejected write/read
module fifo36_sync_model
  import fifo36_pkg::*;
#(
  parameter int unsigned DEPTH               = DEF_DEPTH,
  parameter int unsigned ALMOST_FULL_OFFSET  = DEF_ALMOST_FULL_OFFSET,
  parameter int unsigned ALMOST_EMPTY_OFFSET = DEF_ALMOST_EMPTY_OFFSET,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] io_din,
  input  logic [PAR_W-1:0]  io_dip,
  input  logic              io_wren,
  input  logic              io_rden,
  output logic [DATA_W-1:0] io_dout,
  output logic [PAR_W-1:0]  io_dop,
  output logic              io_full,
  output logic              io_empty,
  output logic              io_almostFull,
  output logic              io_almostEmpty,
  output logic [AW-1:0]     io_wrCount,
  output logic [AW-1:0]     io_rdCount,
  output logic [CW-1:0]     io_count,
  output logic              io_wrErr,
  output logic              io_rdErr
);

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfOffset = CW'(ALMOST_FULL_OFFSET);
  localparam logic [CW-1:0] AeOffset = CW'(ALMOST_EMPTY_OFFSET);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          wr_err_q, rd_err_q;
  logic          push, pop;
  word_t         head;

  always_comb begin
    push     = io_wren && !full_q;
    pop      = io_rden && valid_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    // The RAM reads the next head every edge; it is only valid if that word was
    // written on an earlier edge, i.e. something remains after this pop
    // without counting the write landing on this same edge.
    valid_d  = (count_q - CW'(pop)) != '0;
    full_d   = count_d == DepthCnt;
    afull_d  = (DepthCnt - count_d) <= AfOffset;
    aempty_d = count_d <= AeOffset;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      wr_err_q <= io_wren && full_q;
      rd_err_q <= io_rden && !valid_q;
    end
  end

  // RAM read port register doubles as the FWFT output register.
  fifo36_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({io_din, io_dip}),
    .rd_addr (rd_ptr_d),
    .rd_data (head)
  );

  // Masking keeps the outputs at zero during reset and whenever stale RAM data sits there.
  always_comb begin
    io_dout = valid_q ? head[WORD_W-1:PAR_W] : '0;
    io_dop  = valid_q ? head[PAR_W-1:0]      : '0;
  end

  assign io_full        = full_q;
  assign io_empty       = !valid_q;
  assign io_almostFull  = afull_q;
  assign io_almostEmpty = aempty_q;
  assign io_wrCount     = wr_ptr_q;
  assign io_rdCount     = rd_ptr_q;
  assign io_count       = count_q;
  assign io_wrErr       = wr_err_q;
  assign io_rdErr       = rd_err_q;

endmodule

// File: tb/tb_fifo36_sync_model.sv
// Self-checking bench for fifo36_sync_model: scoreboard queue of written words,
// popped and compared against the head as reads are issued.
module tb_fifo36_sync_model;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] io_din = '0;
  logic [7:0]  io_dip = '0;
  logic        io_wren = 1'b0;
  logic        io_rden = 1'b0;
  logic [63:0] io_dout;
  logic [7:0]  io_dop;
  logic        io_full, io_empty, io_almostFull, io_almostEmpty;
  logic [8:0]  io_wrCount, io_rdCount;
  logic [9:0]  io_count;
  logic        io_wrErr, io_rdErr;

  int checks = 0;
  int errors = 0;

  // Bench-side model
  logic [71:0] sb[$];
  int          m_count = 0;
  logic        m_valid = 1'b0;
  logic        m_wr_err = 1'b0;
  logic        m_rd_err = 1'b0;
  int          m_wr_ptr = 0;
  int          m_rd_ptr = 0;

  always #5 clk = ~clk;

  fifo36_sync_model dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io_din         (io_din),
    .io_dip         (io_dip),
    .io_wren        (io_wren),
    .io_rden        (io_rden),
    .io_dout        (io_dout),
    .io_dop         (io_dop),
    .io_full        (io_full),
    .io_empty       (io_empty),
    .io_almostFull  (io_almostFull),
    .io_almostEmpty (io_almostEmpty),
    .io_wrCount     (io_wrCount),
    .io_rdCount     (io_rdCount),
    .io_count       (io_count),
    .io_wrErr       (io_wrErr),
    .io_rdErr       (io_rdErr)
  );

  function automatic logic [71:0] word_of(input int i);
    return {32'(i) ^ 32'h0123_4567, 32'(i * 7 + 3), 8'(i * 5)};
  endfunction

  task automatic model_clear();
    sb.delete();
    m_count = 0; m_valid = 1'b0; m_wr_err = 1'b0; m_rd_err = 1'b0;
    m_wr_ptr = 0; m_rd_ptr = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    io_wren = 1'b0; io_rden = 1'b0;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock with the given controls; updates the model from spec rules.
  task automatic cycle(input logic wr, input logic rd, input logic [71:0] w);
    logic push, pop;
    push = wr && (m_count < DEPTH);
    pop  = rd && m_valid;
    io_wren = wr; io_rden = rd; {io_din, io_dip} = w;
    @(posedge clk);
    #1;
    m_wr_err = wr && (m_count == DEPTH);
    m_rd_err = rd && !m_valid;
    if (pop) begin sb.delete(0); m_rd_ptr = (m_rd_ptr + 1) % DEPTH; end
    if (push) begin sb.push_back(w); m_wr_ptr = (m_wr_ptr + 1) % DEPTH; end
    m_valid = (m_count - (pop ? 1 : 0)) > 0;
    m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
    io_wren = 1'b0; io_rden = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    #2;
    checks++;
    if ({io_count, io_wrCount, io_rdCount} !== 28'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", io_count, io_wrCount, io_rdCount);
    end
    checks++;
    if ({io_empty, io_full, io_almostEmpty, io_almostFull, io_wrErr, io_rdErr} !== 6'b101000) begin
      errors++; $display("FAIL reset_flags: got %b want 101000",
        {io_empty, io_full, io_almostEmpty, io_almostFull, io_wrErr, io_rdErr});
    end
    checks++;
    if ({io_dout, io_dop} !== 72'd0) begin
      errors++; $display("FAIL reset_dout: got %h want 0", {io_dout, io_dop});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_word();
    logic [71:0] w;
    w = {64'h0123_4567_89AB_CDEF, 8'h5A};
    cycle(1'b1, 1'b0, w);
    checks++;
    if (io_empty !== 1'b1 || io_count !== 10'd1) begin
      errors++; $display("FAIL first_edge1: empty=%b count=%0d want empty=1 count=1", io_empty, io_count);
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (io_empty !== 1'b0 || {io_dout, io_dop} !== sb[0]) begin
      errors++; $display("FAIL first_head: empty=%b data=%h want empty=0 data=%h", io_empty, {io_dout, io_dop}, sb[0]);
    end
    checks++;
    if (io_count !== 10'd1) begin
      errors++; $display("FAIL first_count: got %0d want 1", io_count);
    end
  endtask

  task automatic test_fill_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, word_of(i));
    checks++;
    if (io_full !== 1'b1 || io_count !== 10'(DEPTH)) begin
      errors++; $display("FAIL fill_full: full=%b count=%0d want full=1 count=%0d", io_full, io_count, DEPTH);
    end
    cycle(1'b1, 1'b0, 72'hDEAD_BEEF);
    checks++;
    if (io_wrErr !== m_wr_err || io_count !== 10'(m_count) || io_wrCount !== 9'(m_wr_ptr)) begin
      errors++; $display("FAIL overflow: wrErr=%b count=%0d wrCount=%0d want %b/%0d/%0d",
        io_wrErr, io_count, io_wrCount, m_wr_err, m_count, m_wr_ptr);
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (io_wrErr !== 1'b0) begin
      errors++; $display("FAIL wrerr_pulse: got %b want 0", io_wrErr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (sb.size() == 0 || io_empty !== 1'b0 || {io_dout, io_dop} !== sb[0]) begin
        errors++; $display("FAIL readback[%0d]: empty=%b data=%h want %h", i, io_empty, {io_dout, io_dop},
          (sb.size() != 0) ? sb[0] : 72'hx);
      end
      cycle(1'b0, 1'b1, '0);
    end
    checks++;
    if (io_empty !== 1'b1 || io_count !== 10'd0) begin
      errors++; $display("FAIL drained: empty=%b count=%0d want 1/0", io_empty, io_count);
    end
  endtask

  task automatic test_empty_read();
    apply_reset();
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (io_rdErr !== 1'b1 || io_count !== 10'd0 || io_rdCount !== 9'd0) begin
      errors++; $display("FAIL underflow: rdErr=%b count=%0d rdCount=%0d want 1/0/0", io_rdErr, io_count, io_rdCount);
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (io_rdErr !== 1'b0) begin
      errors++; $display("FAIL rderr_pulse: got %b want 0", io_rdErr);
    end
    cycle(1'b1, 1'b1, word_of(77));
    checks++;
    if (io_count !== 10'd1 || io_rdErr !== m_rd_err || io_rdCount !== 9'd0) begin
      errors++; $display("FAIL wr_rd_empty: count=%0d rdErr=%b rdCount=%0d want 1/%b/0", io_count, io_rdErr,
        io_rdCount, m_rd_err);
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (io_empty !== 1'b0 || {io_dout, io_dop} !== sb[0]) begin
      errors++; $display("FAIL wr_rd_head: empty=%b data=%h want 0/%h", io_empty, {io_dout, io_dop}, sb[0]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, word_of(1000 + i));
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 1000; i++) begin
      checks++;
      if (io_empty !== 1'b0 || {io_dout, io_dop} !== sb[0]) begin
        errors++; $display("FAIL stream_data[%0d]: empty=%b data=%h want %h", i, io_empty, {io_dout, io_dop}, sb[0]);
      end
      cycle(1'b1, 1'b1, word_of(5000 + i));
      checks++;
      if (io_count !== 10'd256) begin
        errors++; $display("FAIL stream_count[%0d]: got %0d want 256", i, io_count);
      end
    end
    checks++;
    if (io_wrCount !== 9'(m_wr_ptr) || io_rdCount !== 9'(m_rd_ptr)) begin
      errors++; $display("FAIL stream_ptrs: wr=%0d rd=%0d want %0d/%0d", io_wrCount, io_rdCount, m_wr_ptr, m_rd_ptr);
    end
  endtask

  task automatic test_thresholds();
    apply_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, word_of(i));
    checks++;
    if (io_almostFull !== 1'b0 || io_almostEmpty !== 1'b1) begin
      errors++; $display("FAIL thr_11: af=%b ae=%b want 0/1", io_almostFull, io_almostEmpty);
    end
    cycle(1'b1, 1'b0, word_of(11));
    checks++;
    if (io_almostFull !== 1'b1) begin
      errors++; $display("FAIL thr_12: af=%b want 1", io_almostFull);
    end
    while (m_count < 500) cycle(1'b1, 1'b0, word_of(m_count));
    checks++;
    if (io_almostFull !== 1'b1 || io_count !== 10'd500) begin
      errors++; $display("FAIL thr_free12: af=%b count=%0d want 1/500", io_almostFull, io_count);
    end
    cycle(1'b1, 1'b0, word_of(500));
    checks++;
    if (io_almostFull !== 1'b1 || io_count !== 10'd501) begin
      errors++; $display("FAIL thr_free11: af=%b count=%0d want 1/501", io_almostFull, io_count);
    end
    while (m_count > 101) begin
      checks++;
      if ({io_dout, io_dop} !== sb[0]) begin
        errors++; $display("FAIL thr_drain: data=%h want %h", {io_dout, io_dop}, sb[0]);
      end
      cycle(1'b0, 1'b1, '0);
    end
    checks++;
    if (io_almostEmpty !== 1'b0 || io_count !== 10'd101) begin
      errors++; $display("FAIL thr_101: ae=%b count=%0d want 0/101", io_almostEmpty, io_count);
    end
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (io_almostEmpty !== 1'b1 || io_count !== 10'd100) begin
      errors++; $display("FAIL thr_100: ae=%b count=%0d want 1/100", io_almostEmpty, io_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] w;
    apply_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, word_of(i));
    io_wren = 1'b1; io_rden = 1'b1; {io_din, io_dip} = word_of(9999);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({io_count, io_wrCount, io_rdCount} !== 28'd0 ||
        {io_empty, io_full, io_almostEmpty, io_almostFull} !== 4'b1010 || {io_dout, io_dop} !== 72'd0) begin
      errors++; $display("FAIL mid_reset: count=%0d wr=%0d rd=%0d flags=%b dout=%h want zeros/1010/0", io_count,
        io_wrCount, io_rdCount, {io_empty, io_full, io_almostEmpty, io_almostFull}, {io_dout, io_dop});
    end
    io_wren = 1'b0; io_rden = 1'b0;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    w = {64'hFEED_FACE_CAFE_0001, 8'hC3};
    cycle(1'b1, 1'b0, w);
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (io_empty !== 1'b0 || {io_dout, io_dop} !== sb[0] || io_count !== 10'd1 || io_wrCount !== 9'd1) begin
      errors++; $display("FAIL fresh_head: empty=%b data=%h count=%0d wr=%0d want 0/%h/1/1", io_empty,
        {io_dout, io_dop}, io_count, io_wrCount, sb[0]);
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill_full();
    test_empty_read();
    test_back_to_back();
    test_thresholds();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
